// File: rtl/ramio_arbiter.sv
// ---------------------------------------------------------------------------
// ramio_arbiter
//   Shares one ramio port (RAM via cache, UART, LEDs) between two requesters:
//   port 0 = load/store unit, port 1 = instruction fetch. A request is
//   arbitrated in IDLE, its command is latched, the ramio handshake is run in
//   ACCESS, and the registered result is returned with a one-cycle done pulse
//   in DONE. Outside ACCESS the ramio bus is parked so address-triggered I/O
//   side effects (UART-in clear, UART-out/LED write) fire only during the
//   owning access.
//
// Parameters
//   AddressBitWidth  address width, both ports and ramio
//   DataBitWidth     data width
//   FixedPriority    1: port 0 always wins; 0: round-robin
//   TimeoutCycles    max ACCESS cycles before a forced abort; 0 disables
//   ParkAddress      ram_address driven while not in ACCESS
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   pN_req                       request, held with its command until pN_done
//   pN_read_type/pN_write_type   ramio type encodings (write_type!=0 = write)
//   pN_address, pN_data_in       command address and write data
//   pN_done                      one-cycle completion pulse
//   pN_data_out                  read result, held until the next pN_done
//   ram_*                        ramio command outputs / status inputs
//   grant                        one-hot owner during ACCESS/DONE, else 0
//   timeout_error                sticky, set on any aborted access
// ---------------------------------------------------------------------------
module ramio_arbiter #(
  parameter int                         AddressBitWidth = 32,
  parameter int                         DataBitWidth    = 32,
  parameter int                         FixedPriority   = 0,
  parameter int                         TimeoutCycles   = 1024,
  parameter logic [AddressBitWidth-1:0] ParkAddress     = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       p0_req,
  input  logic [2:0]                 p0_read_type,
  input  logic [1:0]                 p0_write_type,
  input  logic [AddressBitWidth-1:0] p0_address,
  input  logic [DataBitWidth-1:0]    p0_data_in,
  output logic                       p0_done,
  output logic [DataBitWidth-1:0]    p0_data_out,

  input  logic                       p1_req,
  input  logic [2:0]                 p1_read_type,
  input  logic [1:0]                 p1_write_type,
  input  logic [AddressBitWidth-1:0] p1_address,
  input  logic [DataBitWidth-1:0]    p1_data_in,
  output logic                       p1_done,
  output logic [DataBitWidth-1:0]    p1_data_out,

  output logic                       ram_enable,
  output logic [2:0]                 ram_read_type,
  output logic [1:0]                 ram_write_type,
  output logic [AddressBitWidth-1:0] ram_address,
  output logic [DataBitWidth-1:0]    ram_data_in,
  input  logic [DataBitWidth-1:0]    ram_data_out,
  input  logic                       ram_data_ready,
  input  logic                       ram_busy,

  output logic [1:0]                 grant,
  output logic                       timeout_error
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  // The counter only has to reach TimeoutCycles-1.
  localparam int                CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  logic [1:0]                 state;
  logic                       owner;       // 0: port 0, 1: port 1
  logic                       last_grant;  // port most recently finished
  logic [2:0]                 cmd_read_type;
  logic [1:0]                 cmd_write_type;
  logic [AddressBitWidth-1:0] cmd_address;
  logic [DataBitWidth-1:0]    cmd_data_in;
  logic [CntW-1:0]            access_cnt;

  logic any_req;
  logic winner;
  logic cmd_is_write;
  logic complete;
  logic timed_out;
  logic in_access;
  logic in_done;

  // ---------------------------------------------------------------------
  // Arbitration and completion decode
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    any_req = p0_req | p1_req;
    winner  = 1'b0;
    if (p0_req && p1_req && (FixedPriority == 0))
      winner = ~last_grant;   // round-robin tie: the port not served last
    else
      winner = ~p0_req;       // single requester, or port 0 under fixed priority
  end

  assign cmd_is_write = (cmd_write_type != 2'b00);
  assign complete     = cmd_is_write ? !ram_busy : (!ram_busy && ram_data_ready);
  // Completion in the last allowed cycle still counts as success.
  assign timed_out    = (TimeoutCycles != 0) && (access_cnt == CntLast) && !complete;

  // ---------------------------------------------------------------------
  // FSM and result registers
  // ---------------------------------------------------------------------
  // NOTE: asynchronous active-low reset; all state uses non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      owner          <= 1'b0;
      last_grant     <= 1'b1;   // port 0 wins the first tie
      cmd_read_type  <= '0;
      cmd_write_type <= '0;
      cmd_address    <= '0;
      cmd_data_in    <= '0;
      access_cnt     <= '0;
      p0_data_out    <= '0;
      p1_data_out    <= '0;
      timeout_error  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (any_req) begin
            owner          <= winner;
            cmd_read_type  <= winner ? p1_read_type  : p0_read_type;
            cmd_write_type <= winner ? p1_write_type : p0_write_type;
            cmd_address    <= winner ? p1_address    : p0_address;
            cmd_data_in    <= winner ? p1_data_in    : p0_data_in;
            access_cnt     <= '0;
            state          <= StAccess;
          end
        end

        StAccess: begin
          if (complete) begin
            if (!cmd_is_write) begin
              if (owner) p1_data_out <= ram_data_out;
              else       p0_data_out <= ram_data_out;
            end
            last_grant <= owner;
            state      <= StDone;
          end else if (timed_out) begin
            if (owner) p1_data_out <= '0;
            else       p0_data_out <= '0;
            timeout_error <= 1'b1;
            // An aborted access still counts as a turn so a port that keeps
            // timing out cannot starve the other one.
            last_grant    <= owner;
            state         <= StDone;
          end else begin
            access_cnt <= access_cnt + 1'b1;
          end
        end

        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: the bus carries the latched command only during ACCESS and is
  // parked otherwise.
  // ---------------------------------------------------------------------
  assign in_access = (state == StAccess);
  assign in_done   = (state == StDone);

  assign ram_enable     = in_access;
  assign ram_read_type  = in_access ? cmd_read_type  : 3'b000;
  assign ram_write_type = in_access ? cmd_write_type : 2'b00;
  assign ram_address    = in_access ? cmd_address    : ParkAddress;
  assign ram_data_in    = in_access ? cmd_data_in    : '0;

  assign grant   = (in_access || in_done) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign p0_done = in_done && !owner;
  assign p1_done = in_done &&  owner;

endmodule
